// File: rtl/io_device_regs.sv
// Device-side register block: LED and sound-period registers, square-wave tone, keyboard FIFO.
// Optional: define KEYB_OVF_FLAG_EN to expose the FIFO overflow flag on keyb_char[wordsize-1].
module io_device_regs #(
    parameter int wordsize    = 32,
    parameter int KFIFO_DEPTH = 4,
    parameter int LED_BITS    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [wordsize-1:0] cpu_writedata,
    input  logic                sound_wr,
    input  logic                lights_wr,
    input  logic                keyb_rd,
    input  logic                kb_valid,
    input  logic [7:0]          kb_char,
    output logic [wordsize-1:0] keyb_char,
    output logic [wordsize-1:0] period,
    output logic                audio_out,
    output logic [LED_BITS-1:0] leds
);

    localparam int PW = (KFIFO_DEPTH > 1) ? $clog2(KFIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(KFIFO_DEPTH);

    logic [LED_BITS-1:0] leds_q, leds_d;
    logic [wordsize-1:0] period_q, period_d;
    logic [wordsize-1:0] cnt_q, cnt_d;
    logic                audio_q, audio_d;

    logic [7:0]          mem_q [KFIFO_DEPTH];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                push, pop;

    always_comb begin
        leds_d = leds_q;
        if (lights_wr) begin
            leds_d = cpu_writedata[LED_BITS-1:0];
        end
    end

    // A period write wins over a wrap in the same cycle: counter restarts, no toggle.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        audio_d  = audio_q;
        if (sound_wr) begin
            period_d = cpu_writedata;
            cnt_d    = '0;
            if (cpu_writedata == '0) begin
                audio_d = 1'b0;
            end
        end else if (period_q == '0) begin
            cnt_d   = '0;
            audio_d = 1'b0;
        end else if (cnt_q == period_q - wordsize'(1)) begin
            cnt_d   = '0;
            audio_d = ~audio_q;
        end else begin
            cnt_d = cnt_q + wordsize'(1);
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    always_comb begin
        pop      = keyb_rd && (count_q != '0);
        push     = kb_valid && ((count_q != FULL) || pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            ovf_d    = 1'b0;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (kb_valid && !push) begin
            ovf_d = 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leds_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            audio_q  <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            leds_q   <= leds_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            audio_q  <= audio_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < KFIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= kb_char;
        end
    end

    always_comb begin
        keyb_char = '0;
        if (count_q != '0) begin
            keyb_char[7:0] = mem_q[rd_ptr_q];
`ifdef KEYB_OVF_FLAG_EN
            keyb_char[wordsize-1] = ovf_q;
`else
            // Overflow still tracked for drop behaviour, just not shown.
            keyb_char[wordsize-1] = 1'b0 & ovf_q;
`endif
        end
    end

    assign period    = period_q;
    assign audio_out = audio_q;
    assign leds      = leds_q;

endmodule

// File: tb/tb_io_device_regs.sv
// Directed self-checking bench for io_device_regs.
// Covers reset, LEDs, tone generator and keyboard FIFO.
module tb_io_device_regs;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cpu_writedata;
    logic        sound_wr;
    logic        lights_wr;
    logic        keyb_rd;
    logic        kb_valid;
    logic [7:0]  kb_char;
    logic [31:0] keyb_char;
    logic [31:0] period;
    logic        audio_out;
    logic [15:0] leds;

    int cmp_cnt = 0;
    int err_cnt = 0;

`ifdef KEYB_OVF_FLAG_EN
    localparam logic [31:0] OVF_BIT = 32'h8000_0000;
`else
    localparam logic [31:0] OVF_BIT = 32'h0000_0000;
`endif

    io_device_regs #(
        .wordsize(32),
        .KFIFO_DEPTH(4),
        .LED_BITS(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cpu_writedata(cpu_writedata),
        .sound_wr(sound_wr),
        .lights_wr(lights_wr),
        .keyb_rd(keyb_rd),
        .kb_valid(kb_valid),
        .kb_char(kb_char),
        .keyb_char(keyb_char),
        .period(period),
        .audio_out(audio_out),
        .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sound_wr  = 1'b0;
        lights_wr = 1'b0;
        keyb_rd   = 1'b0;
        kb_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_writedata = '0;
        kb_char = '0;
        idle();
        #2;
        cmp_cnt++;
        if ({audio_out, period, leds, keyb_char} !== '0) begin
            err_cnt++;
            $display("FAIL reset_init got a=%b p=%h l=%h k=%h want 0", audio_out, period, leds, keyb_char);
        end
        #20;
        reset_n = 1'b1;
        tick();
        lights_wr = 1'b1; cpu_writedata = 32'h0000_FFFF;
        tick();
        lights_wr = 1'b0;
        sound_wr = 1'b1; cpu_writedata = 32'd3;
        kb_valid = 1'b1; kb_char = 8'h11;
        tick();
        sound_wr = 1'b0; kb_char = 8'h22;
        tick();
        kb_valid = 1'b0;
        tick();
        tick();
        cmp_cnt++;
        if (audio_out !== 1'b1 || period !== 32'd3 || keyb_char !== 32'h11 || leds !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL pre_reset got a=%b p=%h k=%h l=%h want 1/3/11/ffff", audio_out, period, keyb_char, leds);
        end
        #2;
        reset_n = 1'b0;
        #1;
        cmp_cnt++;
        if ({audio_out, period, leds, keyb_char} !== '0) begin
            err_cnt++;
            $display("FAIL async_reset got a=%b p=%h l=%h k=%h want 0", audio_out, period, leds, keyb_char);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        cmp_cnt++;
        if ({audio_out, period, keyb_char} !== '0) begin
            err_cnt++;
            $display("FAIL post_reset got a=%b p=%h k=%h want 0", audio_out, period, keyb_char);
        end
    endtask

    task automatic test_leds();
        lights_wr = 1'b1; cpu_writedata = 32'h1234_ABCD;
        tick();
        cmp_cnt++;
        if (leds !== 16'hABCD) begin
            err_cnt++;
            $display("FAIL led_write got %h want abcd", leds);
        end
        lights_wr = 1'b0; cpu_writedata = 32'hFFFF_0000;
        tick();
        cmp_cnt++;
        if (leds !== 16'hABCD) begin
            err_cnt++;
            $display("FAIL led_hold got %h want abcd", leds);
        end
    endtask

    task automatic test_sound();
        logic exp;
        sound_wr = 1'b1; cpu_writedata = 32'd3;
        tick();
        sound_wr = 1'b0;
        cmp_cnt++;
        if (audio_out !== 1'b0 || period !== 32'd3) begin
            err_cnt++;
            $display("FAIL snd3_start got a=%b p=%h want 0/3", audio_out, period);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = ((i / 3) % 2) == 1;
            cmp_cnt++;
            if (audio_out !== exp) begin
                err_cnt++;
                $display("FAIL snd3_cyc%0d got %b want %b", i, audio_out, exp);
            end
        end
        sound_wr = 1'b1; cpu_writedata = 32'd0;
        tick();
        sound_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmp_cnt++;
            if (audio_out !== 1'b0 || period !== 32'd0) begin
                err_cnt++;
                $display("FAIL snd0_cyc%0d got a=%b p=%h want 0/0", i, audio_out, period);
            end
            tick();
        end
        sound_wr = 1'b1; cpu_writedata = 32'd1;
        tick();
        sound_wr = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp = (i % 2) == 1;
            cmp_cnt++;
            if (audio_out !== exp) begin
                err_cnt++;
                $display("FAIL snd1_cyc%0d got %b want %b", i, audio_out, exp);
            end
        end
        sound_wr = 1'b1; cpu_writedata = 32'd1;
        tick();
        sound_wr = 1'b0;
        cmp_cnt++;
        if (audio_out !== 1'b0) begin
            err_cnt++;
            $display("FAIL snd_wr_priority got %b want 0", audio_out);
        end
        tick();
        cmp_cnt++;
        if (audio_out !== 1'b1) begin
            err_cnt++;
            $display("FAIL snd_after_rewrite got %b want 1", audio_out);
        end
        sound_wr = 1'b1; cpu_writedata = 32'd0;
        tick();
        sound_wr = 1'b0;
        cmp_cnt++;
        if (audio_out !== 1'b0) begin
            err_cnt++;
            $display("FAIL snd_stop_high got %b want 0", audio_out);
        end
    endtask

    task automatic test_fifo_basic();
        kb_valid = 1'b1; kb_char = 8'h41;
        tick();
        cmp_cnt++;
        if (keyb_char !== 32'h0000_0041) begin
            err_cnt++;
            $display("FAIL fifo_first got %h want 00000041", keyb_char);
        end
        kb_char = 8'h42;
        tick();
        kb_valid = 1'b0;
        cmp_cnt++;
        if (keyb_char !== 32'h0000_0041) begin
            err_cnt++;
            $display("FAIL fifo_head got %h want 00000041", keyb_char);
        end
        keyb_rd = 1'b1;
        tick();
        cmp_cnt++;
        if (keyb_char !== 32'h0000_0042) begin
            err_cnt++;
            $display("FAIL fifo_pop1 got %h want 00000042", keyb_char);
        end
        tick();
        cmp_cnt++;
        if (keyb_char !== 32'h0) begin
            err_cnt++;
            $display("FAIL fifo_pop2 got %h want 0", keyb_char);
        end
        tick();
        keyb_rd = 1'b0;
        cmp_cnt++;
        if (keyb_char !== 32'h0) begin
            err_cnt++;
            $display("FAIL fifo_pop_empty got %h want 0", keyb_char);
        end
        kb_valid = 1'b1; kb_char = 8'h55;
        tick();
        kb_valid = 1'b0;
        cmp_cnt++;
        if (keyb_char !== 32'h0000_0055) begin
            err_cnt++;
            $display("FAIL fifo_ptr_sync got %h want 00000055", keyb_char);
        end
        keyb_rd = 1'b1;
        tick();
        keyb_rd = 1'b0;
        cmp_cnt++;
        if (keyb_char !== 32'h0) begin
            err_cnt++;
            $display("FAIL fifo_drain got %h want 0", keyb_char);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] tail [4] = '{8'h64, 8'h66, 8'h70, 8'h00};
        for (int i = 0; i < 5; i++) begin
            kb_valid = 1'b1; kb_char = 8'(8'h61 + i);
            tick();
        end
        kb_valid = 1'b0;
        cmp_cnt++;
        if (keyb_char !== (OVF_BIT | 32'h61)) begin
            err_cnt++;
            $display("FAIL ovf_head got %h want %h", keyb_char, OVF_BIT | 32'h61);
        end
        keyb_rd = 1'b1;
        tick();
        keyb_rd = 1'b0;
        cmp_cnt++;
        if (keyb_char !== 32'h0000_0062) begin
            err_cnt++;
            $display("FAIL ovf_clear got %h want 00000062", keyb_char);
        end
        kb_valid = 1'b1; kb_char = 8'h66;
        tick();
        kb_char = 8'h70; keyb_rd = 1'b1;
        tick();
        kb_valid = 1'b0; keyb_rd = 1'b0;
        cmp_cnt++;
        if (keyb_char !== 32'h0000_0063) begin
            err_cnt++;
            $display("FAIL full_pushpop got %h want 00000063", keyb_char);
        end
        for (int i = 0; i < 4; i++) begin
            keyb_rd = 1'b1;
            tick();
            keyb_rd = 1'b0;
            cmp_cnt++;
            if (keyb_char !== {24'h0, tail[i]}) begin
                err_cnt++;
                $display("FAIL full_drain%0d got %h want %h", i, keyb_char, {24'h0, tail[i]});
            end
        end
    endtask

    task automatic test_pushpop_empty();
        kb_valid = 1'b1; kb_char = 8'h33; keyb_rd = 1'b1;
        tick();
        kb_valid = 1'b0; keyb_rd = 1'b0;
        cmp_cnt++;
        if (keyb_char !== 32'h0000_0033) begin
            err_cnt++;
            $display("FAIL empty_pushpop got %h want 00000033", keyb_char);
        end
        keyb_rd = 1'b1;
        tick();
        keyb_rd = 1'b0;
        cmp_cnt++;
        if (keyb_char !== 32'h0) begin
            err_cnt++;
            $display("FAIL empty_pushpop_cnt1 got %h want 0", keyb_char);
        end
    endtask

    initial begin
        test_reset();
        test_leds();
        test_sound();
        test_fifo_basic();
        test_overflow();
        test_pushpop_empty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
